// File: rtl/absorption_readout_pkg.sv
// Shared constants, readout FSM states and address packing for the absorption readout.
package absorption_readout_pkg;

    localparam int DEF_NR         = 256;
    localparam int DEF_NZ         = 256;
    localparam int DEF_NR_EXP     = 8;
    localparam int DEF_NZ_EXP     = 8;
    localparam int DEF_ADDR_WIDTH = DEF_NR_EXP + DEF_NZ_EXP;
    localparam int DEF_WORD_WIDTH = 64;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    // Same packing as the fluence updater: addr = (ir << NZ_EXP) + iz
    function automatic logic [31:0] pack_addr(input logic [31:0] ir, input logic [31:0] iz,
                                              input int nz_exp);
        return (ir << nz_exp) + iz;
    endfunction

endpackage

// File: rtl/absorption_readout_fifo.sv
// Output buffer for the readout stream: synchronous ring buffer with full/empty/count.
module readout_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty = (count == '0);
    // A push into a full buffer is fine when the head leaves on the same edge
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    // Head entry comes straight from the storage flops
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/absorption_readout.sv
// Sweeps the NR x NZ absorption RAM and streams each word tagged with (ir, iz).
// Optional CLEAR_ON_READ_EN: zero each location one cycle after it is read.
module absorption_readout
    import absorption_readout_pkg::*;
#(
    parameter int NR         = DEF_NR,
    parameter int NZ         = DEF_NZ,
    parameter int NR_EXP     = DEF_NR_EXP,
    parameter int NZ_EXP     = DEF_NZ_EXP,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [WORD_WIDTH-1:0] q,
    output logic [ADDR_WIDTH-1:0] wraddress,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  wren,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [NR_EXP-1:0]     out_ir,
    output logic [NZ_EXP-1:0]     out_iz
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = WORD_WIDTH + NR_EXP + NZ_EXP;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NR * NZ - 1);

    rd_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] tag_addr;
    // [0]: rdaddress carries a fresh read this cycle, [1]: q carries its data this cycle
    logic [1:0]            vld_pipe;
    logic                  issue, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        committed;
    logic [ENTRY_W-1:0]    fifo_wdata, fifo_rdata;

    assign pop  = out_valid && out_ready;
    assign push = vld_pipe[1];

    // Slots still owed after this edge: post-pop occupancy plus reads in flight
    assign committed = (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop)
                     + (CNT_W+1)'(vld_pipe[0]) + (CNT_W+1)'(vld_pipe[1]);
    assign issue = (state == ST_READ) && (committed < (CNT_W+1)'(FIFO_DEPTH))
                && (!fifo_full || pop);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  if (issue && next_addr == LAST_ADDR) state_nxt = ST_DRAIN;
            ST_DRAIN: if (committed == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rdaddress <= '0;
            next_addr <= '0;
            tag_addr  <= '0;
            vld_pipe  <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[0], issue};
            tag_addr <= rdaddress;
            if (state == ST_DONE) begin
                rdaddress <= '0;
                next_addr <= '0;
            end else if (issue) begin
                rdaddress <= next_addr;
                next_addr <= next_addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign fifo_wdata = {tag_addr[ADDR_WIDTH-1:NZ_EXP], tag_addr[NZ_EXP-1:0], q};

    readout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[WORD_WIDTH-1:0];
    assign out_iz    = fifo_rdata[WORD_WIDTH +: NZ_EXP];
    assign out_ir    = fifo_rdata[WORD_WIDTH+NZ_EXP +: NR_EXP];

`ifdef CLEAR_ON_READ_EN
    // The read of A samples the RAM before this write of A lands
    always_ff @(posedge clock) begin
        if (!reset) begin
            wren      <= 1'b0;
            wraddress <= '0;
        end else begin
            wren      <= vld_pipe[0];
            wraddress <= rdaddress;
        end
    end
    assign data = '0;
`else
    assign wren      = 1'b0;
    assign wraddress = '0;
    assign data      = '0;
`endif

endmodule

// File: tb/tb_absorption_readout.sv
// Scoreboard bench for absorption_readout (NR=NZ=4) with a preloaded RAM model.
module tb_absorption_readout;
    localparam int NR = 4, NZ = 4, NR_EXP = 2, NZ_EXP = 2, AW = 4, WW = 64, FD = 4;
    localparam int NW = NR * NZ;

    logic          clock = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic          busy, done, wren, out_valid;
    logic [AW-1:0] rdaddress, wraddress;
    logic [WW-1:0] q, data, out_data;
    logic [NR_EXP-1:0] out_ir;
    logic [NZ_EXP-1:0] out_iz;

    absorption_readout #(
        .NR(NR), .NZ(NZ), .NR_EXP(NR_EXP), .NZ_EXP(NZ_EXP),
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rdaddress(rdaddress), .q(q), .wraddress(wraddress), .data(data), .wren(wren),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ir(out_ir), .out_iz(out_iz)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: registered read, write port, bulk preload on request
    logic [WW-1:0] mem [NW];
    logic preload = 1'b0;
    always @(posedge clock) begin
        q <= mem[rdaddress];
        if (preload) begin
            for (int i = 0; i < NW; i++) mem[i] <= 64'h1000 + 64'(i);
        end else if (wren) begin
            mem[wraddress] <= data;
        end
    end

    typedef struct { logic [63:0] d; int ir; int iz; } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int done_cnt = 0, done_cyc = -1, first_vld_cyc = -1, rx_cnt = 0, wren_cnt = 0;
    int rmode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one full sweep, row-major over (ir, iz)
    task automatic push_expected();
        for (int k = 0; k < NW; k++) sb.push_back('{64'h1000 + 64'(k), k / NZ, k % NZ});
    endtask

    // Monitor: consumes accepted words against the scoreboard, checks stream rules
    logic          prev_stall = 1'b0, prev_done = 1'b0;
    logic [WW+NR_EXP+NZ_EXP-1:0] prev_word;
    always @(negedge clock) begin
        if (reset) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (prev_done) check("done_single_pulse", 1, 0);
            end
            if (wren) wren_cnt++;
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid_held", 64'(out_valid), 1);
                check("stall_word_stable", 64'({out_ir, out_iz, out_data} != prev_word), 0);
            end
            if (out_valid && out_ready) begin
                rx_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_word", out_data, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_data", out_data, e.d);
                    check("word_ir", 64'(out_ir), 64'(e.ir));
                    check("word_iz", 64'(out_iz), 64'(e.iz));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_ir, out_iz, out_data};
            prev_done  = done;
        end else begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end
    end

    // Ready driver: 0 = always ready, 1 = never ready, 2 = random
    initial forever begin
        @(posedge clock);
        #2;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic do_preload();
        @(negedge clock) preload = 1'b1;
        @(negedge clock) preload = 1'b0;
    endtask

    task automatic pulse_start(output int s);
        @(negedge clock);
        start = 1'b1;
        s = cyc + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            #1;
            if (done_cnt > d0) ok = 1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    initial begin
        int s, d0, r0, a1;
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s, d0, r0, a1;

        // Reset state
        do_preload();
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_wren", 64'(wren), 0);
        check("rst_rdaddress", 64'(rdaddress), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 1: always ready, latency and done timing, start on the done cycle ignored
        rmode = 0;
        wren_cnt = 0;
        first_vld_cyc = -1;
        d0 = done_cnt;
        push_expected();
        pulse_start(s);
        wait_done(100);
        check("first_valid_cycle", 64'(first_vld_cyc), 64'(s + 3));
        check("done_cycle", 64'(done_cyc), 64'(s + NW + 3));
        check("busy_at_done", 64'(busy), 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_done", 64'(busy), 0);
        repeat (10) @(negedge clock);
        check("t1_busy_idle", 64'(busy), 0);
        check("t1_done_count", 64'(done_cnt - d0), 1);
        check("t1_sb_empty", 64'(sb.size()), 0);
`ifdef CLEAR_ON_READ_EN
        check("wren_pulses", 64'(wren_cnt), 64'(NW));
        for (int a = 0; a < NW; a++) check("mem_cleared", mem[a], 0);
`else
        check("wren_pulses", 64'(wren_cnt), 0);
        for (int a = 0; a < NW; a++) check("mem_kept", mem[a], 64'h1000 + 64'(a));
`endif

        // 2: random backpressure
        do_preload();
        rmode = 2;
        d0 = done_cnt;
        push_expected();
        pulse_start(s);
        wait_done(400);
        repeat (3) @(negedge clock);
        check("t2_sb_empty", 64'(sb.size()), 0);
        check("t2_done_count", 64'(done_cnt - d0), 1);

        // 3: consumer stalled for 20 cycles, reads must stop at the buffer depth
        do_preload();
        rmode = 1;
        @(negedge clock);
        r0 = rx_cnt;
        push_expected();
        pulse_start(s);
        repeat (10) @(negedge clock);
        a1 = int'(rdaddress);
        repeat (10) @(negedge clock);
        check("stall_rdaddr_mid", 64'(a1), 64'(FD - 1));
        check("stall_rdaddr_end", 64'(rdaddress), 64'(FD - 1));
        check("stall_valid", 64'(out_valid), 1);
        check("stall_no_accept", 64'(rx_cnt - r0), 0);
        rmode = 0;
        wait_done(100);
        repeat (3) @(negedge clock);
        check("t3_sb_empty", 64'(sb.size()), 0);
        check("t3_rx_count", 64'(rx_cnt - r0), 64'(NW));

        // 4: reset after the 7th word, then a clean restart
        do_preload();
        rmode = 0;
        r0 = rx_cnt;
        d0 = done_cnt;
        push_expected();
        pulse_start(s);
        for (int i = 0; i < 100 && rx_cnt - r0 < 7; i++) @(negedge clock);
        check("t4_reached_word7", 64'(rx_cnt - r0), 7);
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #2;
        check("t4_busy_after_rst", 64'(busy), 0);
        check("t4_valid_after_rst", 64'(out_valid), 0);
        reset = 1'b1;
        sb.delete();
        repeat (8) @(negedge clock);
        check("t4_no_done", 64'(done_cnt - d0), 0);
        check("t4_no_words", 64'(out_valid), 0);
        do_preload();
        d0 = done_cnt;
        push_expected();
        pulse_start(s);
        wait_done(100);
        repeat (3) @(negedge clock);
        check("t4_sb_empty", 64'(sb.size()), 0);
        check("t4_restart_done", 64'(done_cnt - d0), 1);

        // 5: start pulses while busy are ignored
        do_preload();
        rmode = 2;
        r0 = rx_cnt;
        d0 = done_cnt;
        push_expected();
        pulse_start(s);
        for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(1, 3)) @(negedge clock);
            pulse_start(a1);
        end
        wait_done(400);
        repeat (30) @(negedge clock);
        check("t5_done_count", 64'(done_cnt - d0), 1);
        check("t5_rx_count", 64'(rx_cnt - r0), 64'(NW));
        check("t5_sb_empty", 64'(sb.size()), 0);
        check("t5_idle", 64'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
